// File: rtl/shorted_cell_array_if.sv
// Configuration request channel for shorted_cell_array: a valid/ready handshake carrying
// the target channel index and the requested coupling mode.
interface shorted_cell_array_if #(
    parameter int CH_W = 2
) ();
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [1:0]      cfg_mode;

    modport master (output cfg_valid, output cfg_ch, output cfg_mode, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_mode, output cfg_ready);
endinterface

// File: rtl/shorted_cell_array.sv
// N_CH shorted ring-oscillator coupling cells.  The datapath is purely combinational; a
// clocked FSM switches each channel's mode through a bypass settle window.  A synchronised
// per-channel monitor flags phase lock.

module ro_buf_cell (
    input  logic a,
    output logic y
);
    assign y = a;
endmodule

module shorted_cell_array #(
    parameter int N_CH          = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOCK_CYCLES   = 16,
    parameter int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int CNT_W         = $clog2(LOCK_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       sin,
    input  logic [N_CH-1:0]       din,
    output logic [N_CH-1:0]       sout,
    output logic [N_CH-1:0]       dout,
    shorted_cell_array_if.slave   cfg,
    output logic [N_CH-1:0]       locked
);

    localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;
    typedef enum logic [1:0] {M_BYPASS, M_NAND, M_NOR, M_RSVD} mode_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [CH_W-1:0] ch_q;
    mode_t           newmode_q;
    logic            in_range;
    logic            accept;
    logic            apply;
    logic [N_CH-1:0] sel_acc;
    logic [N_CH-1:0] sel_app;

    assign in_range = int'(cfg.cfg_ch) < N_CH;

    always_comb begin
        state_d       = state_q;
        cfg.cfg_ready = 1'b0;
        accept        = 1'b0;
        apply         = 1'b0;
        case (state_q)
            IDLE: begin
                cfg.cfg_ready = 1'b1;
                // Out-of-range requests are consumed by the handshake but start nothing.
                if (cfg.cfg_valid && in_range) begin
                    accept  = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (timer_q == '0) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                apply   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ch_q      <= '0;
            newmode_q <= M_BYPASS;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ch_q      <= cfg.cfg_ch;
                newmode_q <= mode_t'(cfg.cfg_mode);
                timer_q   <= TW'(SETTLE_CYCLES - 1);
            end else if (state_q == DRAIN && timer_q != '0) begin
                timer_q <= timer_q - 1'b1;
            end
        end
    end

    always_comb begin
        sel_acc = '0;
        sel_app = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sel_acc[i] = accept && (cfg.cfg_ch == CH_W'(i));
            sel_app[i] = apply && (ch_q == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mode_t            mode_r;
        logic             s1, s2, d1, d2;
        logic [CNT_W-1:0] cnt;
        logic             lk;
        logic             coupled;
        logic             so_raw, do_raw;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_r <= M_BYPASS;
            end else if (sel_acc[g]) begin
                mode_r <= M_BYPASS;
            end else if (sel_app[g]) begin
                mode_r <= newmode_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
                d1 <= 1'b0;
                d2 <= 1'b0;
            end else begin
                s1 <= sin[g];
                s2 <= s1;
                d1 <= din[g];
                d2 <= d1;
            end
        end

        assign coupled = (mode_r == M_NAND) || (mode_r == M_NOR);

        // Lock asserts on the same edge the counter saturates.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lk  <= 1'b0;
            end else if (!coupled || sel_app[g] || (s2 != d2)) begin
                cnt <= '0;
                lk  <= 1'b0;
            end else if (cnt != CNT_W'(LOCK_CYCLES)) begin
                cnt <= cnt + 1'b1;
                lk  <= (cnt == CNT_W'(LOCK_CYCLES - 1));
            end
        end

        assign locked[g] = lk;

        always_comb begin
            so_raw = ~sin[g];
            do_raw = ~din[g];
            case (mode_r)
                M_NAND: begin
                    so_raw = ~(sin[g] & din[g]);
                    do_raw = ~(sin[g] & din[g]);
                end
                M_NOR: begin
                    so_raw = ~(sin[g] | din[g]);
                    do_raw = ~(sin[g] | din[g]);
                end
                default: ;
            endcase
        end

        ro_buf_cell u_sbuf (.a(so_raw), .y(sout[g]));
        ro_buf_cell u_dbuf (.a(do_raw), .y(dout[g]));
    end

endmodule

// File: tb/tb_shorted_cell_array.sv
`timescale 1ns/100ps
module tb_shorted_cell_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sin = '0, din = '0;
  logic [3:0] sout, dout, locked;
  logic [2:0] sin3 = '0, din3 = '0;
  logic [2:0] sout3, dout3, locked3;

  always #5 clk = ~clk;

  shorted_cell_array_if #(.CH_W(2)) cif ();
  shorted_cell_array_if #(.CH_W(2)) cif3 ();

  shorted_cell_array #(.N_CH(4), .SETTLE_CYCLES(4), .LOCK_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .din(din), .sout(sout), .dout(dout),
    .cfg(cif), .locked(locked));

  shorted_cell_array #(.N_CH(3), .SETTLE_CYCLES(4), .LOCK_CYCLES(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .sin(sin3), .din(din3), .sout(sout3), .dout(dout3),
    .cfg(cif3), .locked(locked3));

  typedef struct {
    string      name;
    int         sel;
    int         bitn;
    logic [3:0] exp;
  } chk_t;

  chk_t q[$];
  event sample_ev;
  int   checks = 0;
  int   failures = 0;
  int   tm[4];

  function automatic logic [3:0] probe(input int sel);
    case (sel)
      0: return sout;
      1: return dout;
      2: return locked;
      3: return {3'b000, cif.cfg_ready};
      4: return {1'b0, sout3};
      5: return {1'b0, dout3};
      6: return {3'b000, cif3.cfg_ready};
      default: return 4'bxxxx;
    endcase
  endfunction

  initial begin
    chk_t       c;
    logic [3:0] act;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        c   = q.pop_front();
        act = probe(c.sel);
        if (c.bitn >= 0) act = {3'b000, act[c.bitn]};
        checks++;
        if (act !== c.exp) begin
          failures++;
          $display("FAIL %s: got %b expected %b", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic push(input string name, input int sel, input int bitn, input logic [3:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.bitn = bitn; c.exp = exp;
    q.push_back(c);
  endtask

  task automatic sample();
    ->sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name);
    logic [3:0] s, d;
    for (int i = 0; i < 4; i++) begin
      case (tm[i])
        1: begin s[i] = ~(sin[i] & din[i]); d[i] = s[i]; end
        2: begin s[i] = ~(sin[i] | din[i]); d[i] = s[i]; end
        default: begin s[i] = ~sin[i]; d[i] = ~din[i]; end
      endcase
    end
    push({name, "_sout"}, 0, -1, s);
    push({name, "_dout"}, 1, -1, d);
  endtask

  task automatic req(input int ch, input int mode);
    cif.cfg_valid = 1'b1;
    cif.cfg_ch    = 2'(ch);
    cif.cfg_mode  = 2'(mode);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cif.cfg_valid = 1'b0; cif.cfg_ch = '0; cif.cfg_mode = '0;
    cif3.cfg_valid = 1'b0; cif3.cfg_ch = '0; cif3.cfg_mode = '0;
    for (int i = 0; i < 4; i++) tm[i] = 0;
    sin = 4'b0101; din = 4'b0011; sin3 = 3'b110; din3 = 3'b001;
    tick(); tick();

    // 1: asynchronous reset mid-cycle
    @(posedge clk); #3; rst_n = 1'b0; #1;
    checks++;
    if (sout3 !== ~sin3) begin
      failures++;
      $display("FAIL t1_direct_sout3: got %b expected %b", sout3, ~sin3);
    end
    checks++;
    if (cif.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL t1_direct_ready: got %b expected 1", cif.cfg_ready);
    end
    checks++;
    if (locked !== 4'b0000) begin
      failures++;
      $display("FAIL t1_direct_locked: got %b expected 0000", locked);
    end
    chk_outs("t1_rst");
    push("t1_ready", 3, -1, 4'b0001);
    push("t1_locked", 2, -1, 4'b0000);
    push("t1_ready3", 6, -1, 4'b0001);
    push("t1_sout3", 4, -1, 4'b0001);
    sample();
    tick(); tick();
    #3; rst_n = 1'b1;

    // 2: ch2 -> NAND, bypass held through settle window
    sin = 4'b0100; din = 4'b0000;
    tick(); tick(); tick();
    req(2, 1);
    tick();
    cif.cfg_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push("t2_ready_drain", 3, -1, 4'b0000);
      push("t2_s2_bypass", 0, 2, 4'b0000);
      push("t2_d2_bypass", 1, 2, 4'b0001);
      chk_outs("t2_drain");
      sample();
      tick();
    end
    tm[2] = 1;
    push("t2_ready_back", 3, -1, 4'b0001);
    push("t2_s2_nand", 0, 2, 4'b0001);
    push("t2_d2_nand", 1, 2, 4'b0001);
    chk_outs("t2_apply");
    sample();
    din[2] = 1'b1; #1;
    push("t2_s2_nand11", 0, 2, 4'b0000);
    push("t2_d2_nand11", 1, 2, 4'b0000);
    sample();

    // 3: lock on ch0, lose it on a mismatch pulse, relock
    sin = 4'b0101; din = 4'b0101;
    tick(); tick(); tick();
    req(0, 1);
    tick();
    cif.cfg_valid = 1'b0;
    repeat (5) tick();
    tm[0] = 1;
    chk_outs("t3_apply");
    sample();
    repeat (15) tick();
    push("t3_lock_pre", 2, 0, 4'b0000);
    sample();
    tick();
    push("t3_lock_rise", 2, 0, 4'b0001);
    sample();
    din[0] = 1'b0;
    tick();
    push("t3_lock_hold1", 2, 0, 4'b0001);
    chk_outs("t3_glitch");
    sample();
    tick();
    push("t3_lock_hold2", 2, 0, 4'b0001);
    sample();
    din[0] = 1'b1;
    tick();
    push("t3_lock_drop", 2, 0, 4'b0000);
    sample();
    repeat (16) tick();
    push("t3_relock_pre", 2, 0, 4'b0000);
    sample();
    tick();
    push("t3_relock", 2, 0, 4'b0001);
    sample();

    // 5: back-to-back requests with cfg_valid held
    sin = 4'b1010; din = 4'b0000;
    tick(); tick();
    req(1, 2);
    tick();
    cif.cfg_ch = 2'd3; cif.cfg_mode = 2'd1;
    for (int k = 0; k < 5; k++) begin
      push("t5_ready_drain", 3, -1, 4'b0000);
      chk_outs("t5_drain1");
      sample();
      tick();
    end
    tm[1] = 2;
    push("t5_ready_back", 3, -1, 4'b0001);
    push("t5_d1_nor", 1, 1, 4'b0000);
    chk_outs("t5_apply1");
    sample();
    tick();
    cif.cfg_valid = 1'b0;
    push("t5_ready_second", 3, -1, 4'b0000);
    chk_outs("t5_accept2");
    sample();
    repeat (4) tick();
    push("t5_s3_bypass", 0, 3, 4'b0000);
    chk_outs("t5_drain2");
    sample();
    tick();
    tm[3] = 1;
    push("t5_s3_nand", 0, 3, 4'b0001);
    chk_outs("t5_apply2");
    sample();
    req(1, 3);
    tick();
    cif.cfg_valid = 1'b0;
    repeat (5) tick();
    tm[1] = 3;
    push("t5_d1_rsvd", 1, 1, 4'b0001);
    chk_outs("t5_rsvd");
    sample();
    din[1] = 1'b1;
    repeat (20) tick();
    push("t5_rsvd_nolock", 2, 1, 4'b0000);
    sample();

    // 4: out-of-range channel on a 3-channel instance
    sin3 = 3'b101; din3 = 3'b011;
    tick();
    cif3.cfg_valid = 1'b1; cif3.cfg_ch = 2'd3; cif3.cfg_mode = 2'd1;
    tick();
    cif3.cfg_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      push("t4_ready3", 6, -1, 4'b0001);
      push("t4_sout3", 4, -1, 4'b0010);
      push("t4_dout3", 5, -1, 4'b0100);
      sample();
      tick();
    end
    cif3.cfg_valid = 1'b1; cif3.cfg_ch = 2'd2; cif3.cfg_mode = 2'd2;
    tick();
    cif3.cfg_valid = 1'b0;
    push("t4_inrange_busy", 6, -1, 4'b0000);
    sample();
    repeat (5) tick();
    push("t4_nor_sout3", 4, -1, 4'b0010);
    push("t4_nor_dout3", 5, -1, 4'b0000);
    push("t4_nor_ready3", 6, -1, 4'b0001);
    sample();

    // 6: reset during DRAIN aborts the pending mode
    sin = 4'b1011; din = 4'b0010;
    tick();
    req(0, 2);
    tick();
    cif.cfg_valid = 1'b0;
    tick(); tick();
    #2; rst_n = 1'b0;
    for (int i = 0; i < 4; i++) tm[i] = 0;
    #1;
    push("t6_rst_ready", 3, -1, 4'b0001);
    push("t6_rst_locked", 2, -1, 4'b0000);
    chk_outs("t6_rst");
    sample();
    tick(); tick();
    #3; rst_n = 1'b1;
    repeat (10) tick();
    push("t6_ready", 3, -1, 4'b0001);
    push("t6_d0_bypass", 1, 0, 4'b0001);
    push("t6_locked", 2, -1, 4'b0000);
    chk_outs("t6_after");
    sample();
    checks++;
    if (sout !== ~sin) begin
      failures++;
      $display("FAIL t6_direct_sout: got %b expected %b", sout, ~sin);
    end
    checks++;
    if (dout !== ~din) begin
      failures++;
      $display("FAIL t6_direct_dout: got %b expected %b", dout, ~din);
    end
    checks++;
    if (cif.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL t6_direct_ready: got %b expected 1", cif.cfg_ready);
    end
    checks++;
    if (locked !== 4'b0000) begin
      failures++;
      $display("FAIL t6_direct_locked: got %b expected 0000", locked);
    end

    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
